// File: rtl/music_pkg.sv
// music_pkg: shared colours, sequencer state encoding and note record for the music device
package music_pkg;
   localparam int NOTE_BITS = 4;
   localparam int OCT_BITS  = 2;
   localparam logic [2:0] COL_BLACK  = 3'b000;
   localparam logic [2:0] COL_RED    = 3'b100;
   localparam logic [2:0] COL_YELLOW = 3'b110;
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} seq_state_t;
   typedef struct packed {
      logic [OCT_BITS-1:0]  octave;
      logic [NOTE_BITS-1:0] note;
   } note_t;
   // Octave plus a signed 2-bit shift, clamped to the representable octave range
   function automatic logic [OCT_BITS-1:0] sat_oct(input logic [OCT_BITS-1:0] o, input logic [1:0] t);
      logic [OCT_BITS+1:0] s;
      s = {2'b00, o} + {{OCT_BITS{t[1]}}, t};
      return s[OCT_BITS+1] ? '0 : s[OCT_BITS] ? '1 : s[OCT_BITS-1:0];
   endfunction
endpackage

// File: rtl/tile_coord.sv
// tile_coord: maps a grid slot index to the top-left pixel of its tile
module tile_coord #(
   parameter int IDX_W  = 4,
   parameter int COLS   = 4,
   parameter int TILE_W = 36,
   parameter int TILE_H = 12,
   parameter int GAP    = 4
) (
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       x,
   output logic [6:0]       y
);
   // Column/row split, each tile preceded by a gap; results truncated to screen widths
   always_comb begin
      x = 8'(GAP + (int'(idx) % COLS) * (TILE_W + GAP));
      y = 7'(GAP + (int'(idx) / COLS) * (TILE_H + GAP));
   end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback note store with tile draw requests; NOTE_SEQ_TRANSPOSE_EN adds octave transpose
module note_sequencer
   import music_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int NOTE_W = NOTE_BITS,
   parameter int OCT_W  = OCT_BITS,
   parameter int COLS   = 4,
   parameter int TILE_W = 36,
   parameter int TILE_H = 12,
   parameter int GAP    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rec_valid,
   input  logic [NOTE_W-1:0]          rec_note,
   input  logic [OCT_W-1:0]           rec_octave,
   output logic                       rec_ready,
   input  logic                       clear,
   input  logic                       play_start,
   input  logic                       play_stop,
   input  logic                       step_tick,
   input  logic                       loop_mode,
   output logic                       note_valid,
   output logic [OCT_W+NOTE_W-1:0]    note_out,
   output logic [$clog2(DEPTH)-1:0]   play_idx,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       playing,
   output logic                       draw_valid,
   output logic [7:0]                 draw_x,
   output logic [6:0]                 draw_y,
   output logic [2:0]                 draw_colour,
   input  logic                       draw_ready
`ifdef NOTE_SEQ_TRANSPOSE_EN
   ,
   input  logic [1:0]                 transpose
`endif
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam bit CFG_OK = (DEPTH >= 2) && (DEPTH <= 64) && ((DEPTH & (DEPTH - 1)) == 0)
                        && (NOTE_W == NOTE_BITS) && (OCT_W == OCT_BITS)
                        && (GAP + (COLS - 1) * (TILE_W + GAP) <= 255)
                        && (GAP + ((DEPTH - 1) / COLS) * (TILE_H + GAP) <= 127);
   seq_state_t       state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n, draw_idx;
   logic [IDX_W:0]   cnt_n;
   logic             fetch_ph, fetch_n, tick_held, held_n, nv_n;
   logic             load_note, wr_en, dq, erase_go, erase_pend, draw_free, tick, last;
   logic [2:0]       dq_col;
   logic [7:0]       tx;
   logic [6:0]       ty;
   logic [OCT_W-1:0] oct_t;
   note_t            mem [DEPTH];
   note_t            rd_q;

   tile_coord #(.IDX_W(IDX_W), .COLS(COLS), .TILE_W(TILE_W), .TILE_H(TILE_H), .GAP(GAP)) u_tile (
      .idx(draw_idx),
      .x  (tx),
      .y  (ty)
   );

`ifdef NOTE_SEQ_TRANSPOSE_EN
   assign oct_t = sat_oct(rd_q.octave, transpose);
`else
   assign oct_t = rd_q.octave;
`endif

   assign full      = count == (IDX_W+1)'(DEPTH);
   assign empty     = count == '0;
   assign playing   = state != IDLE;
   assign play_idx  = ptr;
   assign draw_free = !draw_valid && !erase_pend;
   assign tick      = step_tick || tick_held;
   assign last      = ({1'b0, ptr} + 1'b1) >= count;
   assign erase_go  = (clear || erase_pend) && !draw_valid;
   // Recording only in IDLE with a free draw slot and no higher-priority event this cycle
   assign rec_ready = (state == IDLE) && !full && !draw_valid && !erase_pend && !clear && !play_stop && !play_start;

   // Next-state and event decode, in priority order clear > stop > start > tick > record
   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      cnt_n     = count;
      fetch_n   = fetch_ph;
      held_n    = tick_held;
      nv_n      = note_valid;
      load_note = 1'b0;
      wr_en     = 1'b0;
      dq        = 1'b0;
      dq_col    = COL_RED;
      draw_idx  = ptr;
      if (clear) begin
         cnt_n   = '0;
         nv_n    = 1'b0;
         state_n = IDLE;
         fetch_n = 1'b0;
         held_n  = 1'b0;
      end else if (play_stop) begin
         nv_n    = 1'b0;
         state_n = IDLE;
         fetch_n = 1'b0;
         held_n  = 1'b0;
      end else if (play_start && !empty) begin
         state_n = FETCH;
         ptr_n   = '0;
         fetch_n = 1'b0;
         held_n  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               draw_idx = count[IDX_W-1:0];
               if (rec_valid && rec_ready) begin
                  wr_en = 1'b1;
                  cnt_n = count + 1'b1;
                  dq    = 1'b1;
               end
            end
            FETCH: begin
               if (!fetch_ph) fetch_n = 1'b1;
               else if (draw_free) begin
                  load_note = 1'b1;
                  nv_n      = 1'b1;
                  dq        = 1'b1;
                  dq_col    = COL_YELLOW;
                  fetch_n   = 1'b0;
                  state_n   = HOLD;
               end
            end
            HOLD: begin
               if (tick && draw_free) begin
                  dq     = 1'b1;
                  held_n = 1'b0;
                  if (!last) begin
                     ptr_n   = ptr + 1'b1;
                     state_n = FETCH;
                  end else if (loop_mode) begin
                     ptr_n   = '0;
                     state_n = FETCH;
                  end else begin
                     nv_n    = 1'b0;
                     state_n = IDLE;
                  end
               end else if (tick) held_n = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Control state, current note and the single-entry draw register
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         count       <= '0;
         fetch_ph    <= 1'b0;
         tick_held   <= 1'b0;
         note_valid  <= 1'b0;
         note_out    <= '0;
         erase_pend  <= 1'b0;
         draw_valid  <= 1'b0;
         draw_x      <= '0;
         draw_y      <= '0;
         draw_colour <= '0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         count      <= cnt_n;
         fetch_ph   <= fetch_n;
         tick_held  <= held_n;
         note_valid <= nv_n;
         erase_pend <= (clear || erase_pend) && draw_valid;
         if (load_note) note_out <= {oct_t, rd_q.note};
         if (erase_go) begin
            draw_valid  <= 1'b1;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_colour <= COL_BLACK;
         end else if (dq) begin
            draw_valid  <= 1'b1;
            draw_x      <= tx;
            draw_y      <= ty;
            draw_colour <= dq_col;
         end else if (draw_ready) draw_valid <= 1'b0;
      end
   end

   // Note store with registered read port
   always_ff @(posedge clk) begin
      if (wr_en) mem[count[IDX_W-1:0]] <= '{octave: rec_octave, note: rec_note};
      rd_q <= mem[ptr];
   end

   // Flags parameter sets whose tiles fall off the addressable screen
   always_ff @(posedge clk) begin
      assert (CFG_OK) else $error("note_sequencer: invalid DEPTH/width or tile grid exceeds 8x7-bit screen");
   end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scoreboard bench for note_sequencer
module tb_note_sequencer;
   logic       clk = 0, reset = 1, rec_valid = 0, clear = 0, play_start = 0, play_stop = 0;
   logic       step_tick = 0, loop_mode = 0, draw_ready = 1;
   logic [3:0] rec_note = 0;
   logic [1:0] rec_octave = 0;
   logic       rec_ready, note_valid, full, empty, playing, draw_valid;
   logic [5:0] note_out;
   logic [3:0] play_idx;
   logic [4:0] count;
   logic [7:0] draw_x;
   logic [6:0] draw_y;
   logic [2:0] draw_colour;
`ifdef NOTE_SEQ_TRANSPOSE_EN
   logic [1:0] transpose = 0;
`endif

   note_sequencer dut (
      .clk(clk), .reset(reset), .rec_valid(rec_valid), .rec_note(rec_note), .rec_octave(rec_octave),
      .rec_ready(rec_ready), .clear(clear), .play_start(play_start), .play_stop(play_stop),
      .step_tick(step_tick), .loop_mode(loop_mode), .note_valid(note_valid), .note_out(note_out),
      .play_idx(play_idx), .count(count), .full(full), .empty(empty), .playing(playing),
      .draw_valid(draw_valid), .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
      .draw_ready(draw_ready)
`ifdef NOTE_SEQ_TRANSPOSE_EN
      , .transpose(transpose)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y; int c; bit nchk; int note; int idx;} exp_t;
   exp_t q[$];
   exp_t e_m;
   int checks = 0, failures = 0, n_rec = 0;
   int notes[5] = '{'h14, 'h27, 'h00, 'h39, 'h11};

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int tx(int i); return 4 + (i % 4) * 40; endfunction
   function automatic int ty(int i); return 4 + (i / 4) * 16; endfunction

   task automatic push(input int i, input int c, input bit nchk, input int note);
      q.push_back('{tx(i), ty(i), c, nchk, note, i});
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_tick;
      step_tick = 1; cyc(); step_tick = 0;
   endtask

   task automatic rec(input logic [1:0] o, input logic [3:0] n);
      int k = 0;
      rec_octave = o; rec_note = n; rec_valid = 1;
      while (!rec_ready && k < 20) begin cyc(); k++; end
      if (!rec_ready) begin
         checks++; failures++;
         $display("FAIL rec_timeout: got rec_ready=0 want 1 within 20 cycles");
      end else begin
         push(n_rec, 4, 0, 0);
         n_rec++;
         cyc();
      end
      rec_valid = 0;
   endtask

   task automatic drain;
      int k = 0;
      while (q.size() != 0 && k < 100) begin cyc(); k++; end
      chk("drain_pending", q.size(), 0);
   endtask

   // Scoreboard monitor: every accepted draw is matched against the next expected entry
   always @(negedge clk) begin
      if (!reset && draw_valid && draw_ready) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_draw: got x=%0d y=%0d colour=%0d want none", draw_x, draw_y, draw_colour);
         end else begin
            e_m = q.pop_front();
            chk("draw_x", int'(draw_x), e_m.x);
            chk("draw_y", int'(draw_y), e_m.y);
            chk("draw_colour", int'(draw_colour), e_m.c);
            if (e_m.nchk) begin
               chk("note_out", int'(note_out), e_m.note);
               chk("play_idx", int'(play_idx), e_m.idx);
               chk("note_valid", int'(note_valid), 1);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      cyc(3);
      chk("rst_count", int'(count), 0);
      chk("rst_note_valid", int'(note_valid), 0);
      chk("rst_draw_valid", int'(draw_valid), 0);
      chk("rst_playing", int'(playing), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_note_out", int'(note_out), 0);
      chk("rst_play_idx", int'(play_idx), 0);
      reset = 0;
      cyc();
      rec(1, 4); rec(2, 7); rec(0, 0);
      drain;
      chk("count_3", int'(count), 3);
      chk("empty_3", int'(empty), 0);
      loop_mode = 0;
      push(0, 6, 1, 'h14);
      play_start = 1; cyc(); play_start = 0;
      cyc();
      chk("nv_in_fetch", int'(note_valid), 0);
      chk("playing_fetch", int'(playing), 1);
      cyc();
      chk("nv_after_2", int'(note_valid), 1);
      chk("note_first", int'(note_out), 'h14);
      for (int i = 1; i < 3; i++) begin
         cyc(10);
         push(i - 1, 4, 0, 0);
         push(i, 6, 1, notes[i]);
         pulse_tick;
      end
      cyc(10);
      push(2, 4, 0, 0);
      pulse_tick;
      cyc(3);
      chk("once_idle", int'(playing), 0);
      chk("once_nv", int'(note_valid), 0);
      drain;
      rec(3, 9); rec(1, 1);
      drain;
      chk("count_5", int'(count), 5);
      loop_mode = 1;
      push(0, 6, 1, notes[0]);
      play_start = 1; cyc(); play_start = 0;
      cyc(10);
      for (int i = 1; i <= 5; i++) begin
         push(i - 1, 4, 0, 0);
         push(i % 5, 6, 1, notes[i % 5]);
         pulse_tick;
         cyc(10);
      end
      chk("wrap_idx", int'(play_idx), 0);
      chk("wrap_note", int'(note_out), 'h14);
      chk("wrap_playing", int'(playing), 1);
      play_stop = 1; cyc(); play_stop = 0;
      cyc();
      chk("stop_playing", int'(playing), 0);
      chk("stop_nv", int'(note_valid), 0);
      drain;
      draw_ready = 0;
      push(0, 6, 1, 'h14);
      play_start = 1; cyc(); play_start = 0;
      cyc(2);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (!(draw_valid && draw_x == 8'd4 && draw_y == 7'd4 && draw_colour == 3'b110)) bad++;
         step_tick = (k == 4 || k == 10);
         cyc();
      end
      step_tick = 0;
      chk("stall_unstable_cycles", bad, 0);
      push(0, 4, 0, 0);
      push(1, 6, 1, 'h27);
      draw_ready = 1;
      cyc(20);
      chk("held_idx", int'(play_idx), 1);
      chk("held_playing", int'(playing), 1);
      drain;
      q.push_back('{0, 0, 0, 0, 0, 0});
      clear = 1; play_start = 1; step_tick = 1;
      cyc();
      clear = 0; play_start = 0; step_tick = 0;
      cyc(2);
      chk("clr_count", int'(count), 0);
      chk("clr_playing", int'(playing), 0);
      chk("clr_nv", int'(note_valid), 0);
      chk("clr_empty", int'(empty), 1);
      drain;
      n_rec = 0;
      for (int i = 0; i < 16; i++) begin
         rec(2'(i % 4), 4'(i));
         if (i == 14) chk("full_at_15", int'(full), 0);
      end
      drain;
      chk("full_16", int'(full), 1);
      chk("count_16", int'(count), 16);
      rec_valid = 1; rec_note = 4'd5; rec_octave = 2'd1;
      cyc(5);
      chk("rec_ready_full", int'(rec_ready), 0);
      rec_valid = 0;
      cyc(2);
      chk("count_17th", int'(count), 16);
      chk("full_17th", int'(full), 1);
      cyc(5);
      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
